cdc_rd_arb: RTL and testbench

CDC_RD_ARB -- requirements
Module: cdc_rd_arb

---
 rtl/cdc_pkg.sv | 16 +
 rtl/rr_pick.sv | 41 ++++
 rtl/cdc_rd_arb.sv | 165 ++++++++++++++++
 tb/tb_cdc_rd_arb.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_pkg.sv
// Shared definitions for the read-side FIFO arbiter (cdc_rd_arb).
// Contents:
//   DEF_NREQ, DEF_DW, DEF_BURST_LEN : default parameter values
//   arb_state_t                     : arbiter FSM state encoding (IDLE, SERVE)
package cdc_pkg;

  localparam int unsigned DEF_NREQ      = 3;
  localparam int unsigned DEF_DW        = 32;
  localparam int unsigned DEF_BURST_LEN = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner selection, purely combinational.
// The search starts at last+1 and wraps at NREQ, so the requester granted
// most recently has the lowest priority.
// Ports:
//   req     : per-requester request level
//   last    : index of the previously granted requester
//   win_oh  : one-hot winner (all zero when no request is active)
//   win_idx : binary index of the winner
//   win_vld : at least one request is active
module rr_pick
  import cdc_pkg::*;
#(
  parameter int unsigned NREQ = DEF_NREQ,
  parameter int unsigned IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] win_oh,
  output logic [IW-1:0]   win_idx,
  output logic            win_vld
);

  // Scan the candidates in priority order; the first active one wins.
  always_comb begin
    logic [IW-1:0] cand_s;
    logic          hit_s;
    win_oh  = '0;
    win_idx = '0;
    win_vld = 1'b0;
    cand_s  = '0;
    hit_s   = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand_s          = IW'((32'(last) + k) % NREQ);
      hit_s           = req[cand_s] & ~win_vld;
      win_oh[cand_s]  = win_oh[cand_s] | hit_s;
      win_idx         = hit_s ? cand_s : win_idx;
      win_vld         = win_vld | hit_s;
    end
  end

endmodule

// File: rtl/cdc_rd_arb.sv
// Read-side arbiter for a dual-clock FIFO: shares one show-ahead FIFO read
// port between NREQ requesters and buffers the popped word in a one-entry
// output register tagged with the owner index.
// Optional feature: define CDC_RD_ARB_BURST_EN to let a grant run for up to
// BURST_LEN pops; otherwise every grant ends after exactly one pop.
// Ports:
//   rclk, rrst     : read clock, synchronous active-high reset
//   rempty, rdata  : FIFO empty flag and show-ahead data
//   rpop           : FIFO pop strobe (combinational)
//   req, rready    : per-requester request level and output acceptance
//   gnt            : registered one-hot grant
//   ovalid, odata, oid : output buffer valid, word and owner index
module cdc_rd_arb
  import cdc_pkg::*;
#(
  parameter int unsigned NREQ      = DEF_NREQ,
  parameter int unsigned DW        = DEF_DW,
  parameter int unsigned BURST_LEN = DEF_BURST_LEN
) (
  input  logic                    rclk,
  input  logic                    rrst,
  input  logic                    rempty,
  input  logic [DW-1:0]           rdata,
  output logic                    rpop,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         rready,
  output logic [NREQ-1:0]         gnt,
  output logic                    ovalid,
  output logic [DW-1:0]           odata,
  output logic [$clog2(NREQ)-1:0] oid
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned BW = $clog2(BURST_LEN + 1);

  arb_state_t      state_r, state_s;
  logic [NREQ-1:0] gnt_r, gnt_s;
  logic [IW-1:0]   last_r, last_s;   // current owner while in SERVE
  logic [BW-1:0]   beat_r, beat_s;
  logic            ovalid_r;
  logic [DW-1:0]   odata_r;
  logic [IW-1:0]   oid_r;

  logic [NREQ-1:0] win_oh_s;
  logic [IW-1:0]   win_idx_s;
  logic            win_vld_s;
  logic            rpop_s;
  logic            own_req_s;
  logic            slot_free_s;
  logic            consume_s;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .req     (req),
    .last    (last_r),
    .win_oh  (win_oh_s),
    .win_idx (win_idx_s),
    .win_vld (win_vld_s)
  );

  // Next-state, grant and pop decode.
  always_comb begin
    own_req_s   = req[last_r];
    // Only the owner of the buffered word can free the slot.
    slot_free_s = ~ovalid_r | rready[oid_r];
    consume_s   = ovalid_r & rready[oid_r];
    rpop_s      = 1'b0;
    state_s     = state_r;
    gnt_s       = gnt_r;
    last_s      = last_r;
    beat_s      = beat_r;
    case (state_r)
      IDLE: begin
        gnt_s = '0;
        if (win_vld_s && !rempty) begin
          state_s = SERVE;
          gnt_s   = win_oh_s;
          last_s  = win_idx_s;
          beat_s  = '0;
        end else begin
          state_s = IDLE;
        end
      end
      SERVE: begin
        rpop_s = own_req_s & ~rempty & slot_free_s & ~rrst;
        if (!own_req_s) begin
          state_s = IDLE;
          gnt_s   = '0;
        end else if (rpop_s) begin
          beat_s = beat_r + BW'(1);
`ifdef CDC_RD_ARB_BURST_EN
          if (beat_s == BW'(BURST_LEN)) begin
            state_s = IDLE;
            gnt_s   = '0;
          end else begin
            state_s = SERVE;
          end
`else
          state_s = IDLE;
          gnt_s   = '0;
`endif
        end else begin
`ifdef CDC_RD_ARB_BURST_EN
          // Once a burst has started, running dry at a point where a pop
          // could otherwise happen ends the burst; before the first pop the
          // grant is held while the FIFO is empty.
          if (rempty && slot_free_s && (beat_r != '0)) begin
            state_s = IDLE;
            gnt_s   = '0;
          end else begin
            state_s = SERVE;
          end
`else
          state_s = SERVE;
`endif
        end
      end
      default: begin
        state_s = IDLE;
        gnt_s   = '0;
      end
    endcase
  end

  // Arbiter state registers.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      state_r <= IDLE;
      gnt_r   <= '0;
      last_r  <= IW'(NREQ - 1);
      beat_r  <= '0;
    end else begin
      state_r <= state_s;
      gnt_r   <= gnt_s;
      last_r  <= last_s;
      beat_r  <= beat_s;
    end
  end

  // One-entry output buffer; a pop refills it in the same edge it is consumed.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      ovalid_r <= 1'b0;
      odata_r  <= '0;
      oid_r    <= '0;
    end else if (rpop_s) begin
      ovalid_r <= 1'b1;
      odata_r  <= rdata;
      oid_r    <= last_r;
    end else if (consume_s) begin
      ovalid_r <= 1'b0;
    end else begin
      ovalid_r <= ovalid_r;
    end
  end

  assign rpop   = rpop_s;
  assign gnt    = gnt_r;
  assign ovalid = ovalid_r;
  assign odata  = odata_r;
  assign oid    = oid_r;

endmodule

// File: tb/tb_cdc_rd_arb.sv
// Self-checking bench for cdc_rd_arb. A queue models the FIFO; a transaction
// level round-robin model predicts the owner of every word and pushes
// (owner, data) into a scoreboard that a monitor drains whenever a word is
// accepted at the output.
module tb_cdc_rd_arb;

  localparam int NREQ      = 3;
  localparam int DW        = 32;
  localparam int BURST_LEN = 4;
  localparam int IW        = 2;
`ifdef CDC_RD_ARB_BURST_EN
  localparam int BEATS = BURST_LEN;
`else
  localparam int BEATS = 1;
`endif

  logic            rclk = 1'b0;
  logic            rrst;
  logic            rempty;
  logic [DW-1:0]   rdata;
  logic            rpop;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] rready;
  logic [NREQ-1:0] gnt;
  logic            ovalid;
  logic [DW-1:0]   odata;
  logic [IW-1:0]   oid;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
  } exp_t;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] fifo_q[$];
  exp_t          exp_q[$];
  int            model_last = NREQ - 1;
  int            rready_mode = 0;   // 0: all ones, 1: random, 2: all zeros
  bit            rpop_seen = 1'b0;
  int            pop_cnt = 0;
  bit            mon_en = 1'b0;

  always #5 rclk = ~rclk;

  cdc_rd_arb #(
    .NREQ      (NREQ),
    .DW        (DW),
    .BURST_LEN (BURST_LEN)
  ) dut (
    .rclk   (rclk),
    .rrst   (rrst),
    .rempty (rempty),
    .rdata  (rdata),
    .rpop   (rpop),
    .req    (req),
    .rready (rready),
    .gnt    (gnt),
    .ovalid (ovalid),
    .odata  (odata),
    .oid    (oid)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // One cycle: retire last cycle's pop, drive inputs at negedge, sample rpop.
  task automatic tick();
    @(negedge rclk);
    if (rpop_seen && fifo_q.size() > 0) void'(fifo_q.pop_front());
    case (rready_mode)
      0:       rready = '1;
      1:       rready = NREQ'($urandom);
      default: rready = '0;
    endcase
    rempty = (fifo_q.size() == 0);
    rdata  = rempty ? DW'($urandom) : fifo_q[0];
    #1;
    rpop_seen = rpop;
    if (rpop) pop_cnt++;
  endtask

  // Queue n words with request mask held; predict owners round-robin,
  // BEATS words per grant.
  task automatic load(input logic [NREQ-1:0] mask, input int n, input logic [DW-1:0] base);
    int left;
    int owner;
    int take;
    logic [DW-1:0] w;
    exp_t e;
    req  = mask;
    left = n;
    while (left > 0) begin
      owner = model_last;
      for (int k = 1; k <= NREQ; k++) begin
        if (mask[(model_last + k) % NREQ]) begin
          owner = (model_last + k) % NREQ;
          break;
        end
      end
      take = (left < BEATS) ? left : BEATS;
      for (int j = 0; j < take; j++) begin
        w = (base != 0) ? base + DW'(n - left) : DW'($urandom);
        fifo_q.push_back(w);
        e.id   = IW'(owner);
        e.data = w;
        exp_q.push_back(e);
        left--;
      end
      model_last = owner;
    end
  endtask

  task automatic drain();
    int n = 0;
    if (rready_mode == 2) rready_mode = 0;
    while (!(fifo_q.size() == 0 && !ovalid && gnt == '0 && !rpop_seen) && n < 500) begin
      tick();
      n++;
    end
    check("drain_timeout", 64'(n >= 500), 64'(0));
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    req = '0;
    tick();
  endtask

  // Monitor: protocol checks every cycle and scoreboard compare on accept.
  initial begin
    exp_t e;
    forever begin
      @(negedge rclk);
      #1;
      if (mon_en) begin
        check("no_underflow", 64'(rpop & rempty), 64'(0));
        check("gnt_onehot0", 64'($onehot0(gnt)), 64'(1));
        if (ovalid && rready[oid]) begin
          if (exp_q.size() == 0) begin
            check("unexpected_word", 64'(odata), 64'(0) - 64'(1));
          end else begin
            e = exp_q.pop_front();
            check("oid", 64'(oid), 64'(e.id));
            check("odata", 64'(odata), 64'(e.data));
          end
        end
      end
    end
  end

  initial begin
    int p0;
    int n;
    logic [NREQ-1:0] m;
    rrst   = 1'b1;
    req    = '0;
    rready = '1;
    rempty = 1'b1;
    rdata  = '0;
    repeat (3) tick();
    check("rst_gnt", 64'(gnt), 64'(0));
    check("rst_ovalid", 64'(ovalid), 64'(0));
    check("rst_odata", 64'(odata), 64'(0));
    check("rst_oid", 64'(oid), 64'(0));
    check("rst_rpop", 64'(rpop), 64'(0));
    rrst   = 1'b0;
    mon_en = 1'b1;
    tick();

    // All three requesting, three words: owners follow round-robin from 0.
    load(3'b111, 3, 32'hA0);
    drain();

    // Single requester waiting on an empty FIFO, then one word arrives.
    req = 3'b010;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("empty_no_pop", 64'(rpop), 64'(0));
      check("empty_no_gnt", 64'(gnt), 64'(0));
    end
    load(3'b010, 1, 32'h1234);
    drain();

    // Owner stalls: exactly one pop, then pop coincides with consume.
    rready_mode = 2;
    p0 = pop_cnt;
    load(3'b001, 2, 32'h0);
    repeat (10) tick();
    check("stall_one_pop", 64'(pop_cnt - p0), 64'(1));
    check("stall_ovalid", 64'(ovalid), 64'(1));
    check("stall_rpop", 64'(rpop), 64'(0));
    rready_mode = 0;
    tick();
    check("pop_with_consume", 64'(rpop_seen), 64'(1));
    tick();
    check("no_bubble_ovalid", 64'(ovalid), 64'(1));
    drain();

    // Reset while a word is buffered in SERVE.
    rready_mode = 2;
    load(3'b001, 2, 32'h0);
    n = 0;
    while (!ovalid && n < 20) begin
      tick();
      n++;
    end
    check("pre_rst_ovalid", 64'(ovalid), 64'(1));
    rrst   = 1'b1;
    mon_en = 1'b0;
    #0;
    check("rst_cycle_rpop", 64'(rpop), 64'(0));
    tick();
    check("mid_rst_ovalid", 64'(ovalid), 64'(0));
    check("mid_rst_gnt", 64'(gnt), 64'(0));
    check("mid_rst_rpop", 64'(rpop), 64'(0));
    fifo_q.delete();
    exp_q.delete();
    model_last  = NREQ - 1;
    rpop_seen   = 1'b0;
    req         = '0;
    rready_mode = 0;
    rrst        = 1'b0;
    mon_en      = 1'b1;
    tick();

    // Two requesters, ten words: first grant after reset is requester 0.
    load(3'b011, 10, 32'h100);
    n = 0;
    while (gnt == '0 && n < 20) begin
      tick();
      n++;
    end
    check("first_gnt_after_rst", 64'(gnt), 64'(1));
    drain();

    // Randomized phases with random masks, lengths and acceptance.
    for (int ph = 0; ph < 40; ph++) begin
      m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      rready_mode = $urandom_range(0, 1);
      load(m, $urandom_range(1, 12), 32'h0);
      drain();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
